cosine_arbiter: RTL and testbench

Round-robin scheduler that shares one pipelined cosine CORDIC unit among N_REQ requesters.
- Accepts at most one float32 angle per cycle.
- Tags each issued angle with its requester ID in a token shift register that tracks the fixed pipeline latency.
- Returns each result, tagged, on a registered response port.
- Drives the unit's clk_en so that in-flight data is never zeroed by the stage registers.

---
 rtl/cosine_arbiter.sv | 128 ++++++++++++
 tb/tb_cosine_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cosine_arbiter.sv
// cosine_arbiter
// Round-robin front end that shares one pipelined cosine CORDIC unit among
// N_REQ requesters. Each issued angle is tagged with its requester ID in a
// token shift register that mirrors the unit's fixed latency. The result
// comes back on a registered, tagged response port.
//
// Build option: define COSINE_ARB_CLK_GATE_EN to drive cos_clk_en only while
// tokens occupy the unit's stage registers. Without it, the enable is held
// high outside reset.
module cosine_arbiter #(
    parameter  int N_REQ   = 4,
    parameter  int LATENCY = 4,
    localparam int ID_W    = $clog2(N_REQ),
    localparam int CNT_W   = $clog2(LATENCY + 2)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [32*N_REQ-1:0]  req_angle,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [31:0]          rsp_data,
    output logic [CNT_W-1:0]     inflight,
    output logic [31:0]          cos_angle,
    output logic                 cos_clk_en,
    input  logic [31:0]          cos_result
);

    // Round-robin pointer: the first requester scanned next cycle.
    logic [ID_W-1:0]                r_rr_ptr;

    // Token pipe. Stage k holds the valid flag and owner of the angle that
    // currently sits k+1 register stages deep inside the cosine unit.
    logic [LATENCY-1:0]             r_tv;
    logic [LATENCY-1:0][ID_W-1:0]   r_tid;

    // Response register and outstanding-token counter.
    logic                           r_rsp_valid;
    logic [ID_W-1:0]                r_rsp_id;
    logic [31:0]                    r_rsp_data;
    logic [CNT_W-1:0]               r_inflight;

    // Arbiter results for the current cycle.
    logic                           w_grant;
    logic [ID_W-1:0]                w_gnt_id;
    logic [ID_W-1:0]                w_rr_next;

    // Scan req_valid from r_rr_ptr, wrapping modulo N_REQ. The first set bit wins.
    always_comb begin
        int v_idx;
        // NOTE: every variable gets a default before the scan. A path that
        // leaves one unassigned would infer a latch.
        w_grant  = 1'b0;
        w_gnt_id = '0;
        v_idx    = 0;
        if (!reset) begin
            for (int i = 0; i < N_REQ; i++) begin
                v_idx = int'(r_rr_ptr) + i;
                if (v_idx >= N_REQ) begin
                    v_idx = v_idx - N_REQ;
                end
                if (!w_grant && req_valid[v_idx[ID_W-1:0]]) begin
                    w_grant  = 1'b1;
                    w_gnt_id = ID_W'(v_idx);
                end
            end
        end
    end

    // The pointer moves one position past the granted requester. The wrap is
    // explicit so that N_REQ does not have to be a power of two.
    assign w_rr_next = (w_gnt_id == ID_W'(N_REQ - 1)) ? '0 : w_gnt_id + 1'b1;

    assign req_ready = w_grant ? ({{(N_REQ-1){1'b0}}, 1'b1} << w_gnt_id) : '0;
    assign cos_angle = w_grant ? req_angle[32*int'(w_gnt_id) +: 32] : 32'h0;

    // Advance the round-robin pointer on a grant, and shift the token pipe every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr <= '0;
            r_tv     <= '0;
            r_tid    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments. All
            // registers then update together from the values they held
            // before the clock edge.
            if (w_grant) begin
                r_rr_ptr <= w_rr_next;
            end
            r_tv  <= {r_tv[LATENCY-2:0], w_grant};
            r_tid <= {r_tid[LATENCY-2:0], w_gnt_id};
        end
    end

    // Capture the tagged result as its token leaves the pipe, and track outstanding tokens.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_inflight  <= '0;
        end else begin
            r_rsp_valid <= r_tv[LATENCY-1];
            r_rsp_id    <= r_tid[LATENCY-1];
            if (r_tv[LATENCY-1]) begin
                r_rsp_data <= cos_result;
            end
            // A token is retired in the cycle its response is visible.
            r_inflight <= r_inflight + CNT_W'(w_grant) - CNT_W'(r_rsp_valid);
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign inflight  = r_inflight;

`ifdef COSINE_ARB_CLK_GATE_EN
    // The stage registers advance only while a token sits in one of them.
    // The input register is not gated. The enable comes from registers
    // only, so it has no path from req_valid.
    assign cos_clk_en = |r_tv[LATENCY-2:0];
`else
    assign cos_clk_en = ~reset;
`endif

endmodule

// File: tb/tb_cosine_arbiter.sv
// tb_cosine_arbiter
// Directed bench for cosine_arbiter with N_REQ=4 and LATENCY=4. The cosine
// unit is replaced by a stand-in that has the same latency and clock-enable
// behaviour: an ungated input register followed by three gated stages. A
// gated stage loads zero when the enable is low. The stand-in's transfer
// function is the angle XOR 0x3F800000, which maps 0.0 to exactly 1.0.
// Expected values are therefore exact constants.
// Build option: COSINE_ARB_CLK_GATE_EN selects the gated clk_en expectations.
module tb_cosine_arbiter;

    localparam int N_REQ   = 4;
    localparam int LATENCY = 4;
    localparam logic [31:0] COS_XOR = 32'h3F80_0000;

    logic                clk = 1'b0;
    logic                reset;
    logic [N_REQ-1:0]    req_valid;
    logic [32*N_REQ-1:0] req_angle;
    logic [N_REQ-1:0]    req_ready;
    logic                rsp_valid;
    logic [1:0]          rsp_id;
    logic [31:0]         rsp_data;
    logic [2:0]          inflight;
    logic [31:0]         cos_angle;
    logic                cos_clk_en;
    logic [31:0]         cos_result;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cosine_arbiter #(.N_REQ(N_REQ), .LATENCY(LATENCY)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_angle  (req_angle),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .inflight   (inflight),
        .cos_angle  (cos_angle),
        .cos_clk_en (cos_clk_en),
        .cos_result (cos_result)
    );

    // Stand-in cosine unit: an ungated input register, then three stages that zero when disabled.
    logic [31:0] s_in, s1, s2, s3;
    always_ff @(posedge clk) begin
        s_in <= cos_angle;
        s1   <= cos_clk_en ? s_in : 32'h0;
        s2   <= cos_clk_en ? s1 : 32'h0;
        s3   <= cos_clk_en ? (s2 ^ COS_XOR) : 32'h0;
    end
    assign cos_result = s3;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Move to the next cycle. Inputs are driven 2 time units after the rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        req_angle = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    function automatic logic [31:0] rr_angle(input int c, input int r);
        return 32'h4000_0000 + 32'(c * 16 + r);
    endfunction

    int peak;
    logic exp_en;

    initial begin
        // ---------------- reset state ----------------
        reset     = 1'b1;
        req_valid = 4'b1111;
        req_angle = '0;
        #1;
        check("rst_ready", 32'(req_ready), 32'h0);
        step();
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_id", 32'(rsp_id), 32'h0);
        check("rst_rsp_data", rsp_data, 32'h0);
        check("rst_inflight", 32'(inflight), 32'h0);
        check("rst_ready2", 32'(req_ready), 32'h0);

        // ---------------- single issue ----------------
        do_reset();
        req_valid = 4'b0001;
        req_angle[31:0] = 32'h0;
        #1;
        check("single_ready", 32'(req_ready), 32'h1);
        check("single_angle", cos_angle, 32'h0);
        step();
        req_valid = '0;
        for (int c = 1; c <= 6; c++) begin
            #1;
            check($sformatf("single_rsp_valid_c%0d", c), 32'(rsp_valid), (c == 5) ? 32'h1 : 32'h0);
            check($sformatf("single_inflight_c%0d", c), 32'(inflight), (c <= 5) ? 32'h1 : 32'h0);
            if (c == 5) begin
                check("single_rsp_id", 32'(rsp_id), 32'h0);
                check("single_rsp_data", rsp_data, 32'h3F80_0000);
            end
            step();
        end

        // ---------------- round robin ----------------
        do_reset();
        for (int c = 0; c <= 13; c++) begin
            if (c < 8) begin
                req_valid = 4'b1111;
                for (int r = 0; r < N_REQ; r++) req_angle[32*r +: 32] = rr_angle(c, r);
            end else begin
                req_valid = '0;
            end
            #1;
            if (c < 8) begin
                check($sformatf("rr_ready_c%0d", c), 32'(req_ready), 32'(1) << (c % 4));
                check($sformatf("rr_angle_c%0d", c), cos_angle, rr_angle(c, c % 4));
            end
            check($sformatf("rr_rsp_valid_c%0d", c), 32'(rsp_valid), (c >= 5 && c <= 12) ? 32'h1 : 32'h0);
            if (c >= 5 && c <= 12) begin
                check($sformatf("rr_rsp_id_c%0d", c), 32'(rsp_id), 32'((c - 5) % 4));
                check($sformatf("rr_rsp_data_c%0d", c), rsp_data, rr_angle(c - 5, (c - 5) % 4) ^ COS_XOR);
            end
            step();
        end

        // ---------------- fairness skip ----------------
        do_reset();
        for (int c = 0; c <= 9; c++) begin
            req_valid = (c < 4) ? 4'b1010 : 4'b0000;
            req_angle[32*1 +: 32] = 32'h3000_0000 + 32'(c);
            req_angle[32*3 +: 32] = 32'h3100_0000 + 32'(c);
            #1;
            if (c < 4)
                check($sformatf("fair_ready_c%0d", c), 32'(req_ready), (c % 2 == 0) ? 32'h2 : 32'h8);
            if (c >= 5 && c <= 8) begin
                check($sformatf("fair_rsp_id_c%0d", c), 32'(rsp_id), (c % 2 == 1) ? 32'h1 : 32'h3);
                check($sformatf("fair_rsp_data_c%0d", c), rsp_data,
                      ((c % 2 == 1) ? 32'h3000_0000 : 32'h3100_0000) + 32'(c - 5) ^ COS_XOR);
            end
            step();
        end

        // ---------------- reset mid-flight ----------------
        // The bench leaves the fairness test with rsp_data holding a non-zero result and rr_ptr at 0.
        for (int c = 0; c < 3; c++) begin
            req_valid = 4'b0001;
            req_angle[31:0] = 32'h3E00_0000 + 32'(c);
            #1;
            check($sformatf("mid_ready_c%0d", c), 32'(req_ready), 32'h1);
            step();
        end
        req_valid = '0;
        #1;
        check("mid_inflight_pre", 32'(inflight), 32'h3);
        reset     = 1'b1;
        req_valid = 4'b0001;
        #1;
        check("mid_inflight_rst", 32'(inflight), 32'h0);
        check("mid_rsp_data_rst", rsp_data, 32'h0);
        check("mid_rsp_valid_rst", 32'(rsp_valid), 32'h0);
        check("mid_ready_rst", 32'(req_ready), 32'h0);
        step();
        reset     = 1'b0;
        req_valid = '0;
        for (int c = 4; c <= 8; c++) begin
            #1;
            check($sformatf("mid_rsp_valid_c%0d", c), 32'(rsp_valid), 32'h0);
            check($sformatf("mid_inflight_c%0d", c), 32'(inflight), 32'h0);
            step();
        end

        // ---------------- clock enable ----------------
        do_reset();
        for (int c = 0; c <= 16; c++) begin
            req_valid = (c == 10) ? 4'b0010 : 4'b0000;
            req_angle[32*1 +: 32] = 32'h4049_0FDB;
            #1;
`ifdef COSINE_ARB_CLK_GATE_EN
            exp_en = (c >= 11 && c <= 13);
`else
            exp_en = 1'b1;
`endif
            check($sformatf("clken_c%0d", c), 32'(cos_clk_en), 32'(exp_en));
            if (c == 10) check("clken_ready", 32'(req_ready), 32'h2);
            check($sformatf("clken_rsp_valid_c%0d", c), 32'(rsp_valid), (c == 15) ? 32'h1 : 32'h0);
            if (c == 15) begin
                check("clken_rsp_id", 32'(rsp_id), 32'h1);
                check("clken_rsp_data", rsp_data, 32'h7FC9_0FDB);
            end
            step();
        end

        // ---------------- saturated throughput ----------------
        do_reset();
        peak = 0;
        for (int c = 0; c <= 25; c++) begin
            req_valid = (c < 20) ? 4'b0100 : 4'b0000;
            req_angle[32*2 +: 32] = 32'h4100_0000 + 32'(c);
            #1;
            if (c < 20) check($sformatf("sat_ready_c%0d", c), 32'(req_ready), 32'h4);
            check($sformatf("sat_rsp_valid_c%0d", c), 32'(rsp_valid), (c >= 5 && c < 25) ? 32'h1 : 32'h0);
            if (c >= 5 && c < 25) begin
                check($sformatf("sat_rsp_id_c%0d", c), 32'(rsp_id), 32'h2);
                check($sformatf("sat_rsp_data_c%0d", c), rsp_data, (32'h4100_0000 + 32'(c - 5)) ^ COS_XOR);
            end
            if (int'(inflight) > peak) peak = int'(inflight);
            step();
        end
        check("sat_peak_inflight", 32'(peak), 32'h5);
        #1;
        check("sat_inflight_end", 32'(inflight), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
